// File: rtl/tdm_mux_tx.sv
// tdm_mux_tx -- transmit side of the time-division select/data channel.
//
// Once per frame the N_CH parallel channel bits and the channel mask are
// captured. Every enabled channel is then presented in ascending index order
// on the serial line d, with its index on s, for DWELL cycles each. Masked
// channels are skipped without idle cycles. When the start condition still
// holds at the end of a frame, the next frame follows with no gap.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, highest priority
//   en          transmit enable, evaluated only at frame boundaries
//   ch_in       parallel channel data, bit i = channel i
//   ch_mask     channel enable mask, bit i = 1 transmits channel i
//   d           serialized data bit of the current slot
//   s           channel index of the current slot
//   valid       high while d/s carry a live slot
//   frame_start one-cycle pulse on the first cycle of each frame
//   frame_cnt   completed-frame counter, wraps 255 -> 0

module tdm_mux_tx #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  ch_in,
  input  logic [N_CH-1:0]  ch_mask,
  output logic             d,
  output logic [SEL_W-1:0] s,
  output logic             valid,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [N_CH-1:0]   snap;
  logic [N_CH-1:0]   mask_l;
  logic [3:0]        dwell_cnt;

  logic              start_ok;
  logic              last_cycle;
  logic [SEL_W-1:0]  first_idx;
  logic [SEL_W-1:0]  next_idx;
  logic              next_found;

  // Lowest set bit of a mask; scanning downward leaves the lowest hit last.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (m[i]) idx = SEL_W'(i);
    return idx;
  endfunction

  // Lowest set bit strictly above cur; the MSB of the result flags a hit.
  function automatic logic [SEL_W:0] next_set(input logic [N_CH-1:0] m,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, SEL_W'(i)};
    return r;
  endfunction

  always_comb begin
    start_ok   = en && (ch_mask != '0);
    last_cycle = (dwell_cnt == 4'(DWELL-1));
    first_idx  = lowest_set(ch_mask);
    {next_found, next_idx} = next_set(mask_l, s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= '0;
      mask_l      <= '0;
      dwell_cnt   <= '0;
      d           <= 1'b0;
      s           <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            snap        <= ch_in;
            mask_l      <= ch_mask;
            s           <= first_idx;
            d           <= ch_in[first_idx];
            valid       <= 1'b1;
            frame_start <= 1'b1;
            dwell_cnt   <= '0;
            state       <= SCAN;
          end else begin
            d     <= 1'b0;
            s     <= '0;
            valid <= 1'b0;
          end
        end
        SCAN: begin
          if (!last_cycle) begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end else begin
            dwell_cnt <= '0;
            if (next_found) begin
              s <= next_idx;
              d <= snap[next_idx];
            end else begin
              // Final slot of the frame just ended: count it, then either
              // roll straight into a new frame or drop back to idle.
              frame_cnt <= frame_cnt + 8'd1;
              if (start_ok) begin
                snap        <= ch_in;
                mask_l      <= ch_mask;
                s           <= first_idx;
                d           <= ch_in[first_idx];
                valid       <= 1'b1;
                frame_start <= 1'b1;
              end else begin
                state <= IDLE;
                d     <= 1'b0;
                s     <= '0;
                valid <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux_tx.sv
// Testbench for tdm_mux_tx. Two instances (DWELL=1 and DWELL=2) share the
// same stimulus; each is compared every cycle against a frame-level model
// that expands a frame into a queue of per-cycle slots at its start.
module tb_tdm_mux_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] ch_in = '0;
  logic [3:0] ch_mask = '0;

  logic       d1, v1, fs1;
  logic [1:0] s1;
  logic [7:0] fc1;
  logic       d2, v2, fs2;
  logic [1:0] s2;
  logic [7:0] fc2;

  int checks = 0;
  int errors = 0;

  // Model state: each entry is {frame_start, s[1:0], d} for one cycle.
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [7:0] cnt1 = '0;
  logic [7:0] cnt2 = '0;

  always #5 clk = ~clk;

  tdm_mux_tx #(.N_CH(4), .SEL_W(2), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
    .d(d1), .s(s1), .valid(v1), .frame_start(fs1), .frame_cnt(fc1)
  );

  tdm_mux_tx #(.N_CH(4), .SEL_W(2), .DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
    .d(d2), .s(s2), .valid(v2), .frame_start(fs2), .frame_cnt(fc2)
  );

  // Advance one clock edge of the model using the inputs present at that edge.
  task automatic model_step(inout logic [3:0] q[$], inout logic [7:0] cnt,
                            input int dw);
    logic first;
    logic [3:0] tmp;
    if (rst) begin
      q.delete();
      cnt = '0;
      return;
    end
    if (q.size() > 0) begin
      tmp = q.pop_front();
      if (q.size() == 0) cnt = cnt + 8'd1;
    end
    if (q.size() == 0 && en && ch_mask != 4'b0000) begin
      first = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (ch_mask[c]) begin
          for (int k = 0; k < dw; k++) begin
            q.push_back({first, 2'(c), ch_in[c]});
            first = 1'b0;
          end
        end
      end
    end
  endtask

  // {valid, frame_start, s, d, frame_cnt}
  function automatic logic [12:0] expv(input logic [3:0] q[$], input logic [7:0] cnt);
    if (q.size() > 0) return {1'b1, q[0], cnt};
    return {5'b00000, cnt};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input string tag);
    model_step(q1, cnt1, 1);
    model_step(q2, cnt2, 2);
    @(posedge clk);
    #1;
    chk({tag, "_dw1"}, {v1, fs1, s1, d1, fc1}, expv(q1, cnt1));
    chk({tag, "_dw2"}, {v2, fs2, s2, d2, fc2}, expv(q2, cnt2));
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    // Reset for two cycles, then idle with en low.
    rst = 1'b1;
    cycles("reset", 2);
    chk("reset_zero", {v1, fs1, s1, d1, fc1}, 13'd0);
    rst = 1'b0;
    cycles("idle", 10);
    chk("idle_zero", {v2, fs2, s2, d2, fc2}, 13'd0);

    // Single full frame, en pulsed for one cycle.
    ch_mask = 4'b1111; ch_in = 4'b1010; en = 1'b1;
    cyc("full");
    en = 1'b0;
    chk("full_slot0", {v1, fs1, s1, d1}, 13'({1'b1, 1'b1, 2'd0, 1'b0}));
    cyc("full");
    chk("full_slot1", {v1, fs1, s1, d1}, 13'({1'b1, 1'b0, 2'd1, 1'b1}));
    cyc("full");
    chk("full_slot2", {v1, fs1, s1, d1}, 13'({1'b1, 1'b0, 2'd2, 1'b0}));
    cyc("full");
    chk("full_slot3", {v1, fs1, s1, d1}, 13'({1'b1, 1'b0, 2'd3, 1'b1}));
    cyc("full");
    chk("full_end", {v1, fs1, s1, d1, fc1}, {5'b00000, 8'd1});
    cycles("full_tail", 6);

    // Masked skip with en held high: back-to-back two-slot frames.
    ch_mask = 4'b0101; ch_in = 4'b0100; en = 1'b1;
    cycles("skip", 12);
    en = 1'b0;
    cycles("skip_tail", 6);

    // Snapshot coherency: input changes mid-frame must not reach d.
    ch_mask = 4'b1111; ch_in = 4'b1111; en = 1'b1;
    cyc("coh");
    cycles("coh", 2);
    ch_in = 4'b0000;
    cycles("coh", 10);
    en = 1'b0;
    cycles("coh_tail", 10);

    // en dropped during slot 1: frame still completes.
    ch_mask = 4'b1111; ch_in = 4'b0110; en = 1'b1;
    cycles("endrop", 2);
    en = 1'b0;
    cycles("endrop", 10);

    // Empty mask with en high: nothing is transmitted.
    ch_mask = 4'b0000; en = 1'b1;
    cycles("nomask", 6);
    chk("nomask_valid", {12'd0, v1 | v2}, 13'd0);

    // Reset during slot 2.
    ch_mask = 4'b1111; ch_in = 4'b1001; en = 1'b1;
    cycles("midrst", 3);
    rst = 1'b1;
    cyc("midrst");
    chk("midrst_zero", {v1, fs1, s1, d1, fc1}, 13'd0);
    rst = 1'b0; en = 1'b0;
    cycles("midrst_tail", 4);

    // Counter wrap: single-channel frames back to back.
    ch_mask = 4'b0001; ch_in = 4'b0001; en = 1'b1;
    cycles("wrap", 256);
    chk("wrap_255", {5'd0, fc1}, {5'd0, 8'd255});
    cyc("wrap");
    chk("wrap_0", {5'd0, fc1}, {5'd0, 8'd0});
    cycles("wrap", 300);
    en = 1'b0;
    cycles("wrap_tail", 4);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      ch_in   = 4'($urandom);
      ch_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      rst     = ($urandom_range(0, 63) == 0);
      cyc("rand");
    end
    rst = 1'b0; en = 1'b0;
    cycles("final", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_tx.md
Name: tdm_mux_tx

Overview:
- Time-division multiplexer: the transmitting end of the 1-to-4 select/data channel decoded by the team's demux blocks.
- Snapshots N_CH parallel input bits once per frame.
- Drives them out one at a time on a single data line `d`, with the channel index on `s` and a `valid` strobe.
- A downstream demux reconstructs the channels from `d`/`s`.

Parameters:
- N_CH, 4, number of input channels (power of two, 2..16).
- SEL_W, 2, select width, equals log2(N_CH).
- DWELL, 1, clock cycles each channel slot is held on d/s (1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- en  input  1  transmit enable.
- ch_in  input  N_CH  parallel channel data; bit i is channel i.
- ch_mask  input  N_CH  channel enable mask; bit i=1 means channel i is transmitted.
- d  output  1  serialized data bit of current slot.
- s  output  SEL_W  channel index of current slot.
- valid  output  1  high while d/s carry a live slot.
- frame_start  output  1  one-cycle pulse on the first cycle of each frame.
- frame_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; d=0, s=0, valid=0, frame_start=0, frame_cnt=0; snapshot, latched mask and dwell counter cleared. rst has priority over everything and aborts a frame mid-slot.
- States: IDLE, SCAN.
- Frame start condition: en=1 and ch_mask!=0, sampled at a clock edge while IDLE, or at the last cycle of a frame's final slot.
  - On that edge: snap<=ch_in; mask_l<=ch_mask; s<=lowest set bit index of ch_mask; d<=ch_in[that index]; valid<=1; frame_start<=1; state<=SCAN.
  - Latency: 1 cycle from sampled en to first valid slot.
- SCAN:
  - Each slot holds d/s/valid stable for exactly DWELL cycles (internal dwell counter 0..DWELL-1).
  - At the end of a slot, advance to the next higher index set in mask_l; d<=snap[new index].
  - Masked channels are skipped with no idle cycles.
  - frame_start is high only in the first cycle of the first slot.
- Frame end: at the final cycle of the highest-indexed set channel's slot:
  - frame_cnt increments (mod 256).
  - If the start condition holds, the next frame begins on the next cycle with no gap: valid stays 1, frame_start pulses, new snapshot.
  - Otherwise state<=IDLE; valid<=0, d<=0, s<=0 on the next cycle.
- Coherency: ch_in and ch_mask changes during a frame have no effect until the next frame start.
- en deassert mid-frame: the current frame completes fully; en is only evaluated at frame boundaries.
- ch_mask=0 at a start point: no frame starts; stay or enter IDLE.
- Single-channel mask: frame length = DWELL cycles; back-to-back frames repeat the same s with frame_start every DWELL cycles.
- While IDLE: d=0, s=0, valid=0, frame_start=0; frame_cnt holds.

Test Plan:
- Reset then idle: rst=1 two cycles, en=0 -> d=0, s=0, valid=0, frame_start=0, frame_cnt=0 for 10 cycles.
- Full frame, DWELL=1:
  - Stimulus: en=1 for one cycle, ch_mask=4'b1111, ch_in=4'b1010.
  - Required: from next cycle, (s,d)=(0,0),(1,1),(2,0),(3,1) on consecutive cycles with valid=1; frame_start only at s=0; then valid=0 and frame_cnt=1.
- Masked skip:
  - Stimulus: ch_mask=4'b0101, ch_in=4'b0100, en held 1.
  - Required: slots s=0,d=0 then s=2,d=1, repeating with no gap; frame_start every 2 cycles; frame_cnt +1 per 2 cycles.
- Snapshot coherency, DWELL=2:
  - Stimulus: ch_in=4'b1111 at frame start, changed to 4'b0000 during slot 1.
  - Required: d=1 for all 8 valid cycles, each s held 2 cycles; next frame shows d=0.
- Enable and mask edges:
  - en dropped during slot 1 -> slots 2,3 still sent, then IDLE.
  - ch_mask=0 with en=1 -> valid never asserts.
- Reset mid-frame, wrap:
  - rst=1 during slot 2 -> next cycle all outputs 0, state IDLE.
  - Separately, run 256 frames -> frame_cnt returns to 0.
